rv_iopmp_err_queue: RTL and testbench

//  Multi-instance IOPMP error recorder: arbitrates error reports from NUMBER_IOPMP_INSTANCES checkers.

---
 rtl/rv_iopmp_pkg.sv | 33 +++
 rtl/rv_iopmp_rr_arb.sv | 42 ++++
 rtl/rv_iopmp_err_queue.sv | 149 ++++++++++++++
 tb/tb_rv_iopmp_err_queue.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP error recorder: the per-instance capture, the
// buffered record and the transaction-type codes.
package rv_iopmp_pkg;

    localparam int SRC_IDX_W = 4;
    localparam int SID_W     = 16;

    localparam logic [1:0] TTYPE_READ  = 2'd1;
    localparam logic [1:0] TTYPE_WRITE = 2'd2;

    typedef struct packed {
        logic [1:0]       ttype;
        logic [2:0]       etype;
        logic [SID_W-1:0] sid;
        logic [63:0]      addr;
    } error_capture_t;

    typedef struct packed {
        logic [SRC_IDX_W-1:0] src_idx;
        logic [1:0]           ttype;
        logic [2:0]           etype;
        logic [SID_W-1:0]     sid;
        logic [63:0]          addr;
        logic [31:0]          ts;
    } err_record_t;

    // Only read and write transactions may signal; other ttype codes stay silent.
    function automatic logic wsi_hit(input logic ie, input logic ire, input logic iwe,
                                     input logic pending, input logic [1:0] ttype);
        return ie & pending & ((ire & (ttype == TTYPE_READ)) | (iwe & (ttype == TTYPE_WRITE)));
    endfunction

endpackage

// File: rtl/rv_iopmp_rr_arb.sv
// Round-robin arbiter: priority starts at the requester after the last grant,
// so every source is served within N grants.
module rv_iopmp_rr_arb #(
    parameter int N = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N-1:0]                         req_i,
    output logic [N-1:0]                         gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o,
    output logic                                 gnt_valid_o
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        int idx;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o    = 1'b1;
                gnt_idx_o      = IDX_W'(idx);
                gnt_o[idx]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (gnt_valid_o) begin
            ptr_q <= (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/rv_iopmp_err_queue.sv
// IOPMP error recorder: arbitrates checker reports into an error FIFO, exposes the
// head record and drives the WSI level. Define RV_IOPMP_ERR_TIMESTAMP_EN for record timestamps.
module rv_iopmp_err_queue
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_IOPMP_INSTANCES = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int CNT_W                  = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [NUMBER_IOPMP_INSTANCES-1:0]            err_valid_i,
    input  error_capture_t [NUMBER_IOPMP_INSTANCES-1:0]  err_info_i,
    output err_record_t                                  head_o,
    output logic                                         ip_o,
    input  logic                                         pop_i,
    input  logic                                         ie_i,
    input  logic                                         ire_i,
    input  logic                                         iwe_i,
    output logic                                         wsi_wire_o,
    output logic [CNT_W-1:0]                             drop_cnt_o,
    output logic                                         ovf_o
);

    localparam int N     = NUMBER_IOPMP_INSTANCES;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]         pend_valid_q;
    error_capture_t [N-1:0] pend_info_q;
    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_valid;

    err_record_t          mem_q [FIFO_DEPTH];
    err_record_t          rec;
    error_capture_t       sel_info;
    logic [AW:0]          wr_q, rd_q, count;
    logic                 empty, full, pop_eff, push, full_drop, clear_ovf;
    int                   drops;
    logic [CNT_W:0]       drop_sum;
    logic [CNT_W-1:0]     drop_cnt_q;
    logic                 ovf_q, wsi_q;
    logic [31:0]          ts_now;

    // A held report takes its instance's request slot ahead of any fresh pulse.
    assign req = pend_valid_q | err_valid_i;

    rv_iopmp_rr_arb #(.N(N)) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

`ifdef RV_IOPMP_ERR_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end
    assign ts_now = ts_q;
`else
    assign ts_now = '0;
`endif

    always_comb begin
        sel_info = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) sel_info = pend_valid_q[i] ? pend_info_q[i] : err_info_i[i];
        end
        rec         = '0;
        rec.src_idx = SRC_IDX_W'(gnt_idx);
        rec.ttype   = sel_info.ttype;
        rec.etype   = sel_info.etype;
        rec.sid     = sel_info.sid;
        rec.addr    = sel_info.addr;
        rec.ts      = ts_now;
    end

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count     = wr_q - rd_q;
    assign pop_eff   = pop_i & ~empty;
    assign push      = gnt_valid & (~full | pop_eff);
    assign full_drop = gnt_valid & full & ~pop_eff;
    assign clear_ovf = (count == (AW+1)'(1)) & pop_eff & ~push;

    always_comb begin
        drops = full_drop ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            if (err_valid_i[i] && pend_valid_q[i] && !gnt[i]) drops = drops + 1;
        end
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drops);
    end

    // A granted slot refills only if a new pulse lands on it the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= '0;
            pend_info_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    pend_valid_q[i] <= pend_valid_q[i] & err_valid_i[i];
                    if (pend_valid_q[i] && err_valid_i[i]) pend_info_q[i] <= err_info_i[i];
                end else if (err_valid_i[i] && !pend_valid_q[i]) begin
                    pend_valid_q[i] <= 1'b1;
                    pend_info_q[i]  <= err_info_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q[AW-1:0]] <= rec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q       <= '0;
            rd_q       <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            wsi_q      <= 1'b0;
        end else begin
            if (push)    wr_q <= wr_q + 1'b1;
            if (pop_eff) rd_q <= rd_q + 1'b1;
            if (clear_ovf) begin
                drop_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else if (drops != 0) begin
                drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
                ovf_q      <= 1'b1;
            end
            wsi_q <= wsi_hit(ie_i, ire_i, iwe_i, ip_o, head_o.ttype);
        end
    end

    assign ip_o       = ~empty;
    assign head_o     = ip_o ? mem_q[rd_q[AW-1:0]] : '0;
    assign wsi_wire_o = wsi_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_rv_iopmp_err_queue.sv
// Self-checking bench for rv_iopmp_err_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_rv_iopmp_err_queue;
    import rv_iopmp_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           err_valid;
    error_capture_t [N-1:0] err_info;
    err_record_t            head;
    logic                   ip, pop, ie, ire, iwe, wsi, ovf;
    logic [CW-1:0]          drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rv_iopmp_err_queue #(
        .NUMBER_IOPMP_INSTANCES (N),
        .FIFO_DEPTH             (DEPTH),
        .CNT_W                  (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .err_valid_i (err_valid),
        .err_info_i  (err_info),
        .head_o      (head),
        .ip_o        (ip),
        .pop_i       (pop),
        .ie_i        (ie),
        .ire_i       (ire),
        .iwe_i       (iwe),
        .wsi_wire_o  (wsi),
        .drop_cnt_o  (drop_cnt),
        .ovf_o       (ovf)
    );

    // Reference model: a queue of records, one held report per source, and the
    // index of the last granted source.
    err_record_t    mq[$];
    bit             mpend_v [N];
    error_capture_t mpend   [N];
    int             mlast;
    int             mdrop;
    bit             movf;
    bit             mwsi;
    int unsigned    mts;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < N; i++) begin
            mpend_v[i] = 0;
            mpend[i]   = '0;
        end
        mlast = N - 1;
        mdrop = 0;
        movf  = 0;
        mwsi  = 0;
        mts   = 0;
    endfunction

    function automatic err_record_t exp_head();
        err_record_t r;
        r = '0;
        if (mq.size() > 0) r = mq[0];
        return r;
    endfunction

    task automatic model_step();
        int             g, drops, pre, cand;
        bit             popped, pushed, nwsi;
        err_record_t    r;
        error_capture_t c;
        pre  = mq.size();
        nwsi = ie && (pre > 0) &&
               ((ire && mq[0].ttype == 2'd1) || (iwe && mq[0].ttype == 2'd2));
        g = -1;
        for (int k = 1; k <= N; k++) begin
            cand = (mlast + k) % N;
            if (g < 0 && (mpend_v[cand] || err_valid[cand])) g = cand;
        end
        drops  = 0;
        pushed = 0;
        popped = pop && (pre > 0);
        if (popped) void'(mq.pop_front());
        if (g >= 0) begin
            c         = mpend_v[g] ? mpend[g] : err_info[g];
            r         = '0;
            r.src_idx = SRC_IDX_W'(g);
            r.ttype   = c.ttype;
            r.etype   = c.etype;
            r.sid     = c.sid;
            r.addr    = c.addr;
`ifdef RV_IOPMP_ERR_TIMESTAMP_EN
            r.ts      = mts;
`endif
            mlast = g;
            if (mq.size() < DEPTH) begin
                mq.push_back(r);
                pushed = 1;
            end else begin
                drops++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == g) begin
                if (mpend_v[i] && err_valid[i]) mpend[i] = err_info[i];
                else mpend_v[i] = 0;
            end else if (err_valid[i]) begin
                if (mpend_v[i]) drops++;
                else begin
                    mpend_v[i] = 1;
                    mpend[i]   = err_info[i];
                end
            end
        end
        if (pre == 1 && popped && !pushed) begin
            mdrop = 0;
            movf  = 0;
        end else if (drops > 0) begin
            mdrop = (mdrop + drops > CMAX) ? CMAX : mdrop + drops;
            movf  = 1;
        end
        mts++;
        mwsi = nwsi;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        err_valid = '0;
        pop       = 1'b0;
    endtask

    task automatic pulse(input int inst, input logic [1:0] tt, input logic [63:0] addr);
        error_capture_t c;
        c.ttype  = tt;
        c.etype  = 3'(inst + 1);
        c.sid    = SID_W'(16'h0100 + inst);
        c.addr   = addr;
        err_info[inst]  = c;
        err_valid[inst] = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        err_valid = '0;
        pop       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        err_valid = '0;
        err_info  = '0;
        pop       = 1'b0;
        ie        = 1'b0;
        ire       = 1'b0;
        iwe       = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (ip !== 1'b0 || wsi !== 1'b0 || ovf !== 1'b0 || drop_cnt !== '0 || head !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: ip=%b wsi=%b ovf=%b drop=%0d head=%h, want all zero",
                     ip, wsi, ovf, drop_cnt, head);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        apply_reset();
        ie = 1'b1; ire = 1'b1; iwe = 1'b0;
        pulse(0, TTYPE_READ, 64'h8000_1000);
        tick();
        tests_run++;
        if (ip !== 1'b1 || head.src_idx !== 4'd0 || head.ttype !== 2'd1 || head.addr !== 64'h8000_1000) begin
            tests_failed++;
            $display("[TB] FAIL single_read_head: ip=%b src=%0d ttype=%0d addr=%h, want 1/0/1/80001000",
                     ip, head.src_idx, head.ttype, head.addr);
        end
        tests_run++;
        if (wsi !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_read_wsi_lag: wsi=%b want 0", wsi);
        end
        tick();
        tests_run++;
        if (wsi !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_read_wsi: wsi=%b want 1", wsi);
        end
        ie = 1'b0; ire = 1'b0;
    endtask

    task automatic test_rr_rotation();
        apply_reset();
        pulse(0, TTYPE_READ, 64'hA0);
        pulse(1, TTYPE_READ, 64'hB0);
        tick();
        tests_run++;
        if (head.src_idx !== 4'd0 || head.addr !== 64'hA0) begin
            tests_failed++;
            $display("[TB] FAIL rr_pair1_first: src=%0d addr=%h want 0/a0", head.src_idx, head.addr);
        end
        tick();
        pop = 1'b1;
        tick();
        tests_run++;
        if (head.src_idx !== 4'd1 || head.addr !== 64'hB0) begin
            tests_failed++;
            $display("[TB] FAIL rr_pair1_second: src=%0d addr=%h want 1/b0", head.src_idx, head.addr);
        end
        pop = 1'b1;
        tick();
        pulse(0, TTYPE_WRITE, 64'hC0);
        tick();
        pop = 1'b1;
        tick();
        pulse(0, TTYPE_READ, 64'hD0);
        pulse(1, TTYPE_READ, 64'hE0);
        tick();
        tests_run++;
        if (head.src_idx !== 4'd1 || head.addr !== 64'hE0) begin
            tests_failed++;
            $display("[TB] FAIL rr_pair2_first: src=%0d addr=%h want 1/e0", head.src_idx, head.addr);
        end
        tick();
        pop = 1'b1;
        tick();
        tests_run++;
        if (head.src_idx !== 4'd0 || head.addr !== 64'hD0) begin
            tests_failed++;
            $display("[TB] FAIL rr_pair2_second: src=%0d addr=%h want 0/d0", head.src_idx, head.addr);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(0, TTYPE_READ, 64'(i));
            tick();
        end
        tests_run++;
        if (drop_cnt !== 8'd1 || ovf !== 1'b1 || ip !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_drop: drop=%0d ovf=%b ip=%b want 1/1/1", drop_cnt, ovf, ip);
        end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            tick();
        end
        tests_run++;
        if (ip !== 1'b0 || drop_cnt !== 8'd0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overflow_clear: ip=%b drop=%0d ovf=%b want 0/0/0", ip, drop_cnt, ovf);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            pulse(0, TTYPE_READ, 64'(i));
            tick();
        end
        pulse(0, TTYPE_READ, 64'd4);
        pop = 1'b1;
        tick();
        tests_run++;
        if (drop_cnt !== 8'd0 || ovf !== 1'b0 || head.addr !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop: drop=%0d ovf=%b head_addr=%h want 0/0/1", drop_cnt, ovf, head.addr);
        end
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            tick();
        end
        tests_run++;
        if (ip !== 1'b1 || head.addr !== 64'd4) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop_count: ip=%b head_addr=%h want 1/4", ip, head.addr);
        end
        pop = 1'b1;
        tick();
        tests_run++;
        if (ip !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop_empty: ip=%b want 0", ip);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < DEPTH + CMAX + 40; i++) begin
            pulse(0, TTYPE_READ, 64'(i));
            tick();
        end
        tests_run++;
        if (drop_cnt !== 8'hFF || ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drop_saturate: drop=%0d ovf=%b want 255/1", drop_cnt, ovf);
        end
    endtask

    task automatic test_wsi_write();
        apply_reset();
        ie = 1'b1; ire = 1'b0; iwe = 1'b0;
        pulse(1, TTYPE_WRITE, 64'h1234);
        tick();
        tick();
        tests_run++;
        if (wsi !== 1'b0 || ip !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wsi_write_masked: wsi=%b ip=%b want 0/1", wsi, ip);
        end
        iwe = 1'b1;
        tick();
        tests_run++;
        if (wsi !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wsi_write_enabled: wsi=%b want 1", wsi);
        end
        pop = 1'b1;
        tick();
        tick();
        tests_run++;
        if (wsi !== 1'b0 || ip !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wsi_after_pop: wsi=%b ip=%b want 0/0", wsi, ip);
        end
        ie = 1'b0; iwe = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ie = 1'b1; ire = 1'b1; iwe = 1'b1;
        pulse(0, TTYPE_READ, 64'h10);
        pulse(1, TTYPE_WRITE, 64'h20);
        tick();
        pulse(0, TTYPE_READ, 64'h30);
        tick();
        pulse(0, TTYPE_READ, 64'h40);
        pulse(1, TTYPE_READ, 64'h50);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ip !== 1'b0 || wsi !== 1'b0 || ovf !== 1'b0 || drop_cnt !== '0 || head !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_async: ip=%b wsi=%b ovf=%b drop=%0d head=%h want all zero",
                     ip, wsi, ovf, drop_cnt, head);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ip !== 1'b0 || head !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_ghost: ip=%b head=%h want 0/0", ip, head);
        end
        ie = 1'b0; ire = 1'b0; iwe = 1'b0;
    endtask

    task automatic test_random();
        int pop_pct;
        apply_reset();
        pop_pct = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) pop_pct = (pop_pct == 30) ? 75 : 30;
            if (cyc % 40 == 0) begin
                ie  = 1'($urandom_range(0, 3) != 0);
                ire = 1'($urandom_range(0, 1));
                iwe = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 35) pulse(i, 2'($urandom_range(0, 3)), {$urandom, $urandom});
            end
            pop = 1'($urandom_range(0, 99) < pop_pct);
            tick();
            tests_run++;
            if (head !== exp_head() || ip !== (mq.size() > 0)) begin
                tests_failed++;
                $display("[TB] FAIL rand_head cyc=%0d: ip=%b head=%h, want ip=%b head=%h",
                         cyc, ip, head, (mq.size() > 0), exp_head());
            end
            tests_run++;
            if (wsi !== mwsi || drop_cnt !== CW'(mdrop) || ovf !== movf) begin
                tests_failed++;
                $display("[TB] FAIL rand_status cyc=%0d: wsi=%b drop=%0d ovf=%b, want wsi=%b drop=%0d ovf=%b",
                         cyc, wsi, drop_cnt, ovf, mwsi, mdrop, movf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_rotation();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_wsi_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
